// File: rtl/module_scan_teclado_pkg.sv
// Shared definitions for the 4x4 keypad scanner: FSM states, key map,
// auto-repeat interval and small row-pattern helpers.
package pkg_teclado;

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_PRESSED  = 2'd2,
        ST_RELEASE  = 2'd3
    } state_t;

    // Indexed by {row, column}; entry 0 is row 0 / column 0 ('1').
    localparam logic [15:0][3:0] KEY_MAP = {
        4'd13, 4'd15, 4'd0,  4'd14,   // row 3: *, 0, #, D
        4'd12, 4'd9,  4'd8,  4'd7,    // row 2: 7, 8, 9, C
        4'd11, 4'd6,  4'd5,  4'd4,    // row 1: 4, 5, 6, B
        4'd10, 4'd3,  4'd2,  4'd1     // row 0: 1, 2, 3, A
    };

    // Dwell ticks between auto-repeat pulses while a key stays pressed.
    localparam int REPEAT_SCANS = 500;

    // Active-low one-hot column drive for a column index.
    function automatic logic [3:0] col_drive(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

    // True when exactly one row line is pulled low.
    function automatic logic single_low(input logic [3:0] rows);
        case (rows)
            4'b1110, 4'b1101, 4'b1011, 4'b0111: return 1'b1;
            default:                            return 1'b0;
        endcase
    endfunction

    // Index of the low row line (only meaningful when single_low is true).
    function automatic logic [1:0] low_index(input logic [3:0] rows);
        case (rows)
            4'b1110: return 2'd0;
            4'b1101: return 2'd1;
            4'b1011: return 2'd2;
            4'b0111: return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/module_scan_teclado_if.sv
// Keypad bus: row sense lines in, column drive and key report out.
// slave = scanner side, master = keypad/consumer side.
interface module_scan_teclado_if;
    logic [3:0] row;
    logic [3:0] column;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    modport master (output row, input column, input key_code, input key_valid, input key_held);
    modport slave  (input row, output column, output key_code, output key_valid, output key_held);
endinterface

// File: rtl/module_scan_teclado_divisor.sv
// Dwell tick generator: one-clock pulse every DIV clocks.
module module_divisor_tick #(
    parameter int DIV = 27000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] count_r;
    logic          tick_r;

    // Free-running dwell counter wrapping at DIV-1, registered tick on wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= {CW{1'b0}};
            tick_r  <= 1'b0;
        end else if (count_r == CW'(DIV - 1)) begin
            count_r <= {CW{1'b0}};
            tick_r  <= 1'b1;
        end else begin
            count_r <= count_r + CW'(1);
            tick_r  <= 1'b0;
        end
    end

    assign tick = tick_r;
endmodule

// File: rtl/module_scan_teclado.sv
// 4x4 matrix keypad scanner with debounce on press and release.
// Optional build macro KEY_REPEAT_EN: re-pulse key_valid every
// REPEAT_SCANS ticks while a key remains pressed.
module module_scan_teclado
    import pkg_teclado::*;
#(
    parameter int SCAN_DIV       = 27000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    module_scan_teclado_if.slave  kp
);
    localparam int CW = $clog2(DEBOUNCE_SCANS + 1);

    logic [3:0]    row_meta_r, row_sync_r;
    logic          tick_s;
    state_t        state_r, state_s;
    logic [1:0]    row_idx_r, row_idx_s;
    logic [1:0]    col_idx_r, col_idx_s;
    logic [CW-1:0] count_r, count_s, count_inc_s;
    logic [3:0]    column_r, column_s;
    logic [3:0]    key_code_r, key_code_s;
    logic          key_valid_r, key_valid_s;
    logic          key_held_r, key_held_s;
    logic          hit_s, same_s, all_high_s;
`ifdef KEY_REPEAT_EN
    localparam int RW = $clog2(REPEAT_SCANS + 1);
    logic [RW-1:0] rep_r, rep_s, rep_inc_s;
`endif

    module_divisor_tick #(.DIV(SCAN_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick_s)
    );

    // Two-flop synchronizer for the asynchronous row lines (idle high).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_meta_r <= 4'b1111;
            row_sync_r <= 4'b1111;
        end else begin
            row_meta_r <= kp.row;
            row_sync_r <= row_meta_r;
        end
    end

    assign hit_s       = single_low(row_sync_r);
    assign same_s      = hit_s && (low_index(row_sync_r) == row_idx_r);
    assign all_high_s  = (row_sync_r == 4'b1111);
    assign count_inc_s = (count_r == CW'(DEBOUNCE_SCANS)) ? count_r : count_r + CW'(1);
`ifdef KEY_REPEAT_EN
    assign rep_inc_s   = (rep_r == RW'(REPEAT_SCANS)) ? rep_r : rep_r + RW'(1);
`endif

    // Next-state and output decode; decisions are taken only on tick.
    always_comb begin
        state_s     = state_r;
        row_idx_s   = row_idx_r;
        col_idx_s   = col_idx_r;
        count_s     = count_r;
        key_code_s  = key_code_r;
        key_valid_s = 1'b0;
`ifdef KEY_REPEAT_EN
        rep_s       = rep_r;
`endif
        case (state_r)
            ST_SCAN: begin
                if (tick_s && hit_s) begin
                    row_idx_s = low_index(row_sync_r);
                    count_s   = {CW{1'b0}};
                    state_s   = ST_DEBOUNCE;
                end else if (tick_s) begin
                    col_idx_s = col_idx_r + 2'd1;
                end else begin
                    state_s = ST_SCAN;
                end
            end
            ST_DEBOUNCE: begin
                if (tick_s && same_s) begin
                    count_s = count_inc_s;
                    if (count_inc_s == CW'(DEBOUNCE_SCANS)) begin
                        state_s     = ST_PRESSED;
                        key_code_s  = KEY_MAP[{row_idx_r, col_idx_r}];
                        key_valid_s = 1'b1;
`ifdef KEY_REPEAT_EN
                        rep_s       = {RW{1'b0}};
`endif
                    end else begin
                        state_s = ST_DEBOUNCE;
                    end
                end else if (tick_s) begin
                    count_s   = {CW{1'b0}};
                    col_idx_s = col_idx_r + 2'd1;
                    state_s   = ST_SCAN;
                end else begin
                    state_s = ST_DEBOUNCE;
                end
            end
            ST_PRESSED: begin
                if (tick_s && all_high_s) begin
                    count_s = {CW{1'b0}};
                    state_s = ST_RELEASE;
                end else if (tick_s) begin
`ifdef KEY_REPEAT_EN
                    if (rep_inc_s == RW'(REPEAT_SCANS)) begin
                        key_valid_s = 1'b1;
                        rep_s       = {RW{1'b0}};
                    end else begin
                        rep_s = rep_inc_s;
                    end
`else
                    state_s = ST_PRESSED;
`endif
                end else begin
                    state_s = ST_PRESSED;
                end
            end
            ST_RELEASE: begin
                if (tick_s && all_high_s) begin
                    count_s = count_inc_s;
                    if (count_inc_s == CW'(DEBOUNCE_SCANS)) begin
                        col_idx_s = col_idx_r + 2'd1;
                        state_s   = ST_SCAN;
                    end else begin
                        state_s = ST_RELEASE;
                    end
                end else if (tick_s) begin
                    count_s = {CW{1'b0}};
                    state_s = ST_PRESSED;
                end else begin
                    state_s = ST_RELEASE;
                end
            end
            default: begin
                state_s   = ST_SCAN;
                count_s   = {CW{1'b0}};
                col_idx_s = 2'd0;
            end
        endcase
        key_held_s = (state_s == ST_PRESSED) || (state_s == ST_RELEASE);
        column_s   = col_drive(col_idx_s);
    end

    // FSM state, counters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_SCAN;
            row_idx_r   <= 2'd0;
            col_idx_r   <= 2'd0;
            count_r     <= {CW{1'b0}};
            column_r    <= 4'b1110;
            key_code_r  <= 4'd0;
            key_valid_r <= 1'b0;
            key_held_r  <= 1'b0;
`ifdef KEY_REPEAT_EN
            rep_r       <= {RW{1'b0}};
`endif
        end else begin
            state_r     <= state_s;
            row_idx_r   <= row_idx_s;
            col_idx_r   <= col_idx_s;
            count_r     <= count_s;
            column_r    <= column_s;
            key_code_r  <= key_code_s;
            key_valid_r <= key_valid_s;
            key_held_r  <= key_held_s;
`ifdef KEY_REPEAT_EN
            rep_r       <= rep_s;
`endif
        end
    end

    assign kp.column    = column_r;
    assign kp.key_code  = key_code_r;
    assign kp.key_valid = key_valid_r;
    assign kp.key_held  = key_held_r;
endmodule

// File: tb/tb_module_scan_teclado.sv
// Bench for module_scan_teclado: physical keypad model, randomized key
// presses and a scoreboard matching key_valid pulses against expected codes.
module tb_module_scan_teclado;
    localparam int SCAN_DIV = 4;
    localparam int DEB      = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] pressed = 16'h0000;
    logic [3:0]  keypad_rows;
    int          errors = 0;
    int          checks = 0;
    int          exp_q[$];
    string       keys = "123A456B789C*0#D";

    module_scan_teclado_if kp ();

    module_scan_teclado #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_SCANS(DEB)) dut (
        .clk (clk),
        .rst (rst),
        .kp  (kp)
    );

    always #5 clk = ~clk;

    // Keypad matrix: a row reads low if a pressed key sits in a driven column.
    always_comb begin
        keypad_rows = 4'b1111;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && kp.column[c] == 1'b0) keypad_rows[r] = 1'b0;
    end
    assign kp.row = keypad_rows;

    function automatic int code_of(input byte ch);
        if (ch >= "0" && ch <= "9") return int'(ch - "0");
        if (ch >= "A" && ch <= "D") return int'(ch - "A") + 10;
        if (ch == "*") return 14;
        return 15;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_held(input logic lvl, input int budget, input string name);
        int n = 0;
        while (kp.key_held !== lvl && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, {31'd0, kp.key_held}, {31'd0, lvl});
    endtask

    task automatic push_key(input int idx);
        exp_q.push_back(code_of(keys[idx]));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_column"}, {28'd0, kp.column}, 32'hE);
        check({tag, "_code"}, {28'd0, kp.key_code}, 32'h0);
        check({tag, "_valid"}, {31'd0, kp.key_valid}, 32'h0);
        check({tag, "_held"}, {31'd0, kp.key_held}, 32'h0);
    endtask

    // Scoreboard monitor: every key_valid pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && kp.key_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: key_code=%0d with nothing expected", kp.key_code);
            end else begin
                check("key_code", {28'd0, kp.key_code}, exp_q.pop_front());
                check("held_at_valid", {31'd0, kp.key_held}, 32'h1);
            end
        end
    end

    // Hard time limit so the run always terminates.
    initial begin
        #2000000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        logic [3:0] prev;
        int last, nchg, n, idx;

        cycles(3);
        check_reset_outputs("reset");
        rst = 1'b0;

        // Idle scanning: rotate left every SCAN_DIV clocks, no key reports.
        prev = kp.column; last = 0; nchg = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (kp.column !== prev) begin
                check("col_rotation", {28'd0, kp.column}, {28'd0, prev[2:0], prev[3]});
                if (nchg > 0) check("col_period", i - last, SCAN_DIV);
                last = i; prev = kp.column; nchg++;
            end
        end
        check("col_activity", (nchg >= 8) ? 32'd1 : 32'd0, 32'd1);

        // Key '6' (row 1, column 2), then release; scanning resumes at 0111.
        push_key(6);
        pressed[6] = 1'b1;
        wait_held(1'b1, 100, "k6_held");
        cycles(20);
        pressed[6] = 1'b0;
        cycles(4);
        check("k6_release_not_early", {31'd0, kp.key_held}, 32'h1);
        wait_held(1'b0, 80, "k6_released");
        check("k6_resume_column", {28'd0, kp.column}, 32'h7);

        // Bouncing 'D' aligned to ticks: alternate press/release each dwell.
        n = 0;
        while (kp.column === 4'b0111 && n < 100) begin @(negedge clk); n++; end
        while (kp.column !== 4'b0111 && n < 100) begin @(negedge clk); n++; end
        check("bounce_align", {28'd0, kp.column}, 32'h7);
        for (int k = 0; k < 12; k++) begin
            pressed[15] = (k % 2 == 0);
            cycles(SCAN_DIV);
        end
        pressed[15] = 1'b0;
        cycles(20);
        check("bounce_no_hold", {31'd0, kp.key_held}, 32'h0);
        push_key(15);
        pressed[15] = 1'b1;
        wait_held(1'b1, 100, "kD_held");
        cycles(10);
        pressed[15] = 1'b0;
        wait_held(1'b0, 80, "kD_released");

        // Two rows low together ('1' and '4') is ignored.
        pressed[0] = 1'b1; pressed[4] = 1'b1;
        cycles(100);
        check("multi_row_ignored", {31'd0, kp.key_held}, 32'h0);
        pressed[0] = 1'b0; pressed[4] = 1'b0;
        cycles(20);

        // Reset while '#' is held, then one fresh report after reset.
        push_key(14);
        pressed[14] = 1'b1;
        wait_held(1'b1, 100, "khash_held");
        cycles(6);
        rst = 1'b1;
        cycles(2);
        check_reset_outputs("midpress_reset");
        cycles(2);
        push_key(14);
        rst = 1'b0;
        wait_held(1'b1, 100, "khash_reheld");
        cycles(10);
        pressed[14] = 1'b0;
        wait_held(1'b0, 80, "khash_released");

        // Randomized single-key presses with randomized hold and gap lengths.
        for (int t = 0; t < 20; t++) begin
            idx = $urandom_range(0, 15);
            push_key(idx);
            pressed[idx] = 1'b1;
            cycles($urandom_range(60, 150));
            pressed[idx] = 1'b0;
            cycles($urandom_range(40, 80));
            check("rand_released", {31'd0, kp.key_held}, 32'h0);
        end

`ifdef KEY_REPEAT_EN
        // Hold '5' for 1100 ticks: initial report plus two repeats.
        repeat (3) push_key(5);
        pressed[5] = 1'b1;
        cycles(1100 * SCAN_DIV);
        pressed[5] = 1'b0;
        cycles(60);
`endif

        cycles(10);
        check("all_expected_seen", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/module_scan_teclado.md
MODULE_SCAN_TECLADO -- requirements
Module: module_scan_teclado

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 27000, giving clk cycles per column dwell (1 kHz step at 27 MHz).
REQ-002 SHALL have parameter DEBOUNCE_SCANS, default 4, giving the consecutive stable dwell ticks required to accept a press or a release.
REQ-003 SHALL use one clock; reset is asynchronous and active-high.
REQ-004 clk  input  1  system clock (27 MHz).
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 row  input  4  keypad rows, active-low (pulled up), asynchronous to clk.
REQ-007 column  output  4  keypad column drive, active-low one-hot.
REQ-008 key_code  output  4  code of the accepted key, held until the next accepted key.
REQ-009 key_valid  output  1  one-clk pulse when key_code is updated.
REQ-010 key_held  output  1  high while an accepted key remains pressed.

Function
REQ-011 row SHALL pass through a 2-FF synchronizer before any use.
REQ-012 Internal tick SHALL pulse for 1 clk every SCAN_DIV clks; all FSM decisions SHALL occur only on tick.
REQ-013 FSM states: SCAN, DEBOUNCE, PRESSED, RELEASE.
REQ-014 SCAN: on each tick, sample the synchronized row; if exactly one bit is low, latch row and column indices, clear the debounce count, freeze column, and go to DEBOUNCE; otherwise rotate column 1110->1101->1011->0111->1110.
REQ-015 SCAN with 0 or 2+ row bits low SHALL be ignored and scanning SHALL continue.
REQ-016 DEBOUNCE: on each tick where the same single row is low, increment the count; on count==DEBOUNCE_SCANS go to PRESSED; any other row pattern SHALL clear the count and return to SCAN, advancing column.
REQ-017 On entry to PRESSED, key_code SHALL be updated and key_valid SHALL pulse on the clk after the qualifying tick (latency 1 clk).
REQ-018 Key map (row r, column c), codes 0-15: r0: 1,2,3,10(A); r1: 4,5,6,11(B); r2: 7,8,9,12(C); r3: 14(*),0,15(#),13(D).
REQ-019 PRESSED: key_held=1; column stays frozen; a tick with all rows high SHALL go to RELEASE with the count cleared.
REQ-020 RELEASE: each tick with all rows high SHALL increment the count; at count==DEBOUNCE_SCANS, key_held SHALL drop and the FSM SHALL return to SCAN with column advanced; any low row SHALL return to PRESSED with no new key_valid.
REQ-021 A second key in the frozen column during PRESSED/RELEASE SHALL be ignored (no key_valid) until a full release.
REQ-022 Counters SHALL saturate and never wrap; the dwell counter SHALL wrap from SCAN_DIV-1 to 0.

Reset
REQ-023 On rst: column=4'b1110, key_code=0, key_valid=0, key_held=0, state=SCAN, all counters=0, synchronizer=4'b1111.
REQ-024 rst asserted mid-press SHALL abort immediately; after deassertion, a still-held key SHALL be re-debounced and reported once.

Configuration
REQ-025 Macro KEY_REPEAT_EN defined: while in PRESSED, key_valid SHALL re-pulse with the same key_code every REPEAT_SCANS ticks (package constant, 500).
REQ-026 KEY_REPEAT_EN undefined: exactly one key_valid per press; no repeat counter is synthesized.

Structure
REQ-027 Package pkg_teclado SHALL hold the FSM state typedef, the 16-entry key map constant, and REPEAT_SCANS.
REQ-028 Sub-module module_divisor_tick (parameter DIV) SHALL generate tick; the FSM, synchronizer and map SHALL stay in module_scan_teclado.

Verification (bench: SCAN_DIV=4, DEBOUNCE_SCANS=2)
REQ-029 Reset, no keys -> column cycles 1110,1101,1011,0111 every 4 clks; key_valid never asserts.
REQ-030 Hold row=1101 while column=1011 -> after 2 stable ticks, key_valid pulses once with key_code=6 and key_held=1; release -> key_held=0 after 2 ticks, scanning resumes at 0111.
REQ-031 Row bounces (low on 1 tick, high on the next) at column 0111 row 0111 -> no key_valid; a clean hold then gives key_code=13.
REQ-032 Rows 1100 together -> ignored; no key_valid.
REQ-033 rst pulse during PRESSED with '#' held -> outputs at reset values; after deassertion, one key_valid with key_code=15.
REQ-034 With KEY_REPEAT_EN, hold '5' for 1100 ticks -> 3 key_valid pulses, all key_code=5.
